// File: rtl/cordic_sample_sequencer.sv
`default_nettype none
// ============================================================================
// cordic_sample_sequencer : tagged I/Q FIFO feeding the iterative CORDIC engine,
// with a valid/ready result slot and a watchdog that drops lost jobs.
// Revision 1.0
// ============================================================================
module cordic_sample_sequencer #(
   parameter int INPUT_WIDTH = 16,
   parameter int INT_WIDTH   = 32,
   parameter int TAG_WIDTH   = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic signed [INPUT_WIDTH-1:0]     s_x,
   input  logic signed [INPUT_WIDTH-1:0]     s_y,
   input  logic        [TAG_WIDTH-1:0]       s_tag,
   output logic                              eng_start,
   output logic signed [INPUT_WIDTH-1:0]     eng_x,
   output logic signed [INPUT_WIDTH-1:0]     eng_y,
   input  logic                              eng_busy,
   input  logic                              eng_done,
   input  logic signed [INT_WIDTH-1:0]       eng_magnitude,
   input  logic signed [INT_WIDTH-1:0]       eng_phase,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic signed [INT_WIDTH-1:0]       m_magnitude,
   output logic signed [INT_WIDTH-1:0]       m_phase,
   output logic        [TAG_WIDTH-1:0]       m_tag,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
   output logic                              err_timeout
);
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = TAG_WIDTH + 2 * INPUT_WIDTH;
   localparam int WDOG_W  = $clog2(TIMEOUT + 1);
   // Counter restarts at 0 the cycle after START, so this value lands the
   // abort exactly TIMEOUT cycles after the start pulse.
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   logic [ENTRY_W-1:0]            mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]              level_q, level_d;
   state_t                        state_q, state_d;
   logic                          eng_start_q, eng_start_d;
   logic signed [INPUT_WIDTH-1:0] eng_x_q, eng_x_d;
   logic signed [INPUT_WIDTH-1:0] eng_y_q, eng_y_d;
   logic [TAG_WIDTH-1:0]          tag_q, tag_d;
   logic                          m_valid_q, m_valid_d;
   logic signed [INT_WIDTH-1:0]   m_mag_q, m_mag_d;
   logic signed [INT_WIDTH-1:0]   m_phase_q, m_phase_d;
   logic [TAG_WIDTH-1:0]          m_tag_q, m_tag_d;
   logic                          err_q, err_d;
   logic [WDOG_W-1:0]             wdog_q, wdog_d;

   logic                          w_s_ready;
   logic                          w_push;
   logic                          w_issue;
   logic                          w_slot_free;
   logic [ENTRY_W-1:0]            w_head;

   assign w_s_ready   = !rst && (level_q < LVL_W'(FIFO_DEPTH));
   assign w_push      = s_valid && w_s_ready;
   assign w_slot_free = !m_valid_q || m_ready;
   assign w_head      = mem_q[rd_ptr_q];
   // Holding off on busy/done keeps a start out of an engine still finishing
   // a job that this block abandoned through reset or timeout.
   assign w_issue     = (state_q == ST_IDLE) && (level_q != '0) && w_slot_free
                        && !eng_busy && !eng_done;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_issue) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_issue})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      eng_start_d = 1'b0;
      eng_x_d     = eng_x_q;
      eng_y_d     = eng_y_q;
      tag_d       = tag_q;
      m_valid_d   = m_valid_q;
      m_mag_d     = m_mag_q;
      m_phase_d   = m_phase_q;
      m_tag_d     = m_tag_q;
      err_d       = err_q;
      wdog_d      = wdog_q;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (w_issue) begin
               eng_x_d     = w_head[INPUT_WIDTH-1:0];
               eng_y_d     = w_head[2*INPUT_WIDTH-1:INPUT_WIDTH];
               tag_d       = w_head[ENTRY_W-1:2*INPUT_WIDTH];
               eng_start_d = 1'b1;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            wdog_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               m_valid_d = 1'b1;
               m_mag_d   = eng_magnitude;
               m_phase_d = eng_phase;
               m_tag_d   = tag_q;
               state_d   = ST_IDLE;
            end else if (wdog_q == WDOG_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {s_tag, s_y, s_x};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         state_q     <= ST_IDLE;
         eng_start_q <= 1'b0;
         eng_x_q     <= '0;
         eng_y_q     <= '0;
         tag_q       <= '0;
         m_valid_q   <= 1'b0;
         m_mag_q     <= '0;
         m_phase_q   <= '0;
         m_tag_q     <= '0;
         err_q       <= 1'b0;
         wdog_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         state_q     <= state_d;
         eng_start_q <= eng_start_d;
         eng_x_q     <= eng_x_d;
         eng_y_q     <= eng_y_d;
         tag_q       <= tag_d;
         m_valid_q   <= m_valid_d;
         m_mag_q     <= m_mag_d;
         m_phase_q   <= m_phase_d;
         m_tag_q     <= m_tag_d;
         err_q       <= err_d;
         wdog_q      <= wdog_d;
      end
   end

   assign s_ready     = w_s_ready;
   assign eng_start   = eng_start_q;
   assign eng_x       = eng_x_q;
   assign eng_y       = eng_y_q;
   assign m_valid     = m_valid_q;
   assign m_magnitude = m_mag_q;
   assign m_phase     = m_phase_q;
   assign m_tag       = m_tag_q;
   assign fifo_level  = level_q;
   assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sample_sequencer.sv
`default_nettype none
// Directed bench for cordic_sample_sequencer with a behavioural 32-iteration engine.
module tb_cordic_sample_sequencer;
   localparam int IW = 16, DW = 32, TW = 8, DEPTH = 4, TMO = 64, ITER = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s_valid = 1'b0, s_ready;
   logic signed [IW-1:0] s_x = '0, s_y = '0;
   logic [TW-1:0] s_tag = '0;
   logic eng_start, eng_busy, eng_done;
   logic signed [IW-1:0] eng_x, eng_y;
   logic signed [DW-1:0] eng_magnitude, eng_phase;
   logic m_valid, m_ready = 1'b1;
   logic signed [DW-1:0] m_magnitude, m_phase;
   logic [TW-1:0] m_tag;
   logic [2:0] fifo_level;
   logic err_timeout;

   int tests = 0, failed = 0;

   cordic_sample_sequencer #(
      .INPUT_WIDTH(IW), .INT_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
      .s_tag(s_tag), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
      .eng_busy(eng_busy), .eng_done(eng_done), .eng_magnitude(eng_magnitude),
      .eng_phase(eng_phase), .m_valid(m_valid), .m_ready(m_ready),
      .m_magnitude(m_magnitude), .m_phase(m_phase), .m_tag(m_tag),
      .fifo_level(fifo_level), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f_mag(input logic signed [15:0] x, input logic signed [15:0] y);
      logic signed [31:0] xe, ye;
      xe = x;
      ye = y;
      return 32'(xe * xe + ye * ye);
   endfunction

   function automatic logic [31:0] f_ph(input logic signed [15:0] x, input logic signed [15:0] y);
      return {x, y};
   endfunction

   // Engine: done arrives ITER+2 cycles after start; hang suppresses done only.
   logic mdl_busy = 1'b0, mdl_prev_start = 1'b0, hang = 1'b0;
   int   mdl_cnt = 0, viol = 0;
   logic [31:0] mdl_mag = '0, mdl_ph = '0;
   always @(posedge clk) begin
      if (eng_start && (mdl_busy || mdl_prev_start)) viol <= viol + 1;
      mdl_prev_start <= eng_start;
      if (eng_start) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= ITER + 1;
         mdl_mag  <= f_mag(eng_x, eng_y);
         mdl_ph   <= f_ph(eng_x, eng_y);
      end else if (mdl_busy) begin
         if (mdl_cnt == 0) mdl_busy <= 1'b0;
         else mdl_cnt <= mdl_cnt - 1;
      end
   end
   assign eng_busy      = mdl_busy;
   assign eng_done      = mdl_busy && (mdl_cnt == 0) && !hang;
   assign eng_magnitude = mdl_mag;
   assign eng_phase     = mdl_ph;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
      tick(); tick(); tick();
      tests++;
      if (s_ready !== 1'b0) begin failed++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
      tests++;
      if ({eng_start, eng_x, eng_y, m_valid, m_magnitude, m_phase, m_tag, fifo_level, err_timeout} !== '0) begin
         failed++;
         $display("FAIL reset_outputs: start=%0b x=%0h y=%0h mv=%0b mag=%0h ph=%0h tag=%0h lvl=%0d err=%0b expected all 0",
                  eng_start, eng_x, eng_y, m_valid, m_magnitude, m_phase, m_tag, fifo_level, err_timeout);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (s_ready !== 1'b1) begin failed++; $display("FAIL post_reset_s_ready: got %0b expected 1", s_ready); end
      tick();
   endtask

   task automatic test_single();
      int t;
      s_x = 16'sd3; s_y = 16'sd4; s_tag = 8'h11; s_valid = 1'b1; m_ready = 1'b1;
      tick(); s_valid = 1'b0;
      tests++;
      if (fifo_level !== 3'd1 || eng_start !== 1'b0) begin
         failed++; $display("FAIL single_c1: lvl=%0d start=%0b expected lvl=1 start=0", fifo_level, eng_start);
      end
      tick();
      tests++;
      if (eng_start !== 1'b1 || eng_x !== 16'sd3 || eng_y !== 16'sd4) begin
         failed++; $display("FAIL single_c2: start=%0b x=%0d y=%0d expected 1,3,4", eng_start, eng_x, eng_y);
      end
      tick();
      tests++;
      if (eng_start !== 1'b0 || fifo_level !== 3'd0) begin
         failed++; $display("FAIL single_c3: start=%0b lvl=%0d expected 0,0", eng_start, fifo_level);
      end
      t = 3;
      while (!m_valid && t < 200) begin tick(); t++; end
      tests++;
      if (t !== 37) begin failed++; $display("FAIL single_latency: got cycle %0d expected 37", t); end
      tests++;
      if (m_magnitude !== 32'd25 || m_phase !== 32'h0003_0004 || m_tag !== 8'h11) begin
         failed++; $display("FAIL single_data: mag=%0h ph=%0h tag=%0h expected 19,30004,11", m_magnitude, m_phase, m_tag);
      end
      tick();
      tests++;
      if (m_valid !== 1'b0) begin failed++; $display("FAIL single_drain: m_valid=%0b expected 0", m_valid); end
   endtask

   task automatic test_burst();
      int sent, got, lvl, t, last_t;
      bit acc, saw_full;
      sent = 0; got = 0; lvl = 0; t = 0; last_t = 0; saw_full = 1'b0;
      m_ready = 1'b1;
      while (got < 6 && t < 400) begin
         s_valid = (sent < 6);
         s_x = 16'(10 * sent + 1); s_y = -16'(sent); s_tag = 8'hA0 + 8'(sent);
         #1;
         tests++;
         if (s_ready !== (lvl < DEPTH)) begin failed++; $display("FAIL burst_s_ready t=%0d: got %0b expected %0b", t, s_ready, lvl < DEPTH); end
         tests++;
         if (fifo_level !== 3'(lvl)) begin failed++; $display("FAIL burst_level t=%0d: got %0d expected %0d", t, fifo_level, lvl); end
         if (lvl == DEPTH) saw_full = 1'b1;
         acc = s_valid && (lvl < DEPTH);
         @(posedge clk); #1; t++;
         if (acc) begin sent++; lvl++; end
         if (eng_start) lvl--;
         if (m_valid) begin
            tests++;
            if (m_tag !== 8'hA0 + 8'(got) || m_magnitude !== f_mag(16'(10 * got + 1), -16'(got))
                || m_phase !== f_ph(16'(10 * got + 1), -16'(got))) begin
               failed++; $display("FAIL burst_data[%0d]: tag=%0h mag=%0h expected tag=%0h", got, m_tag, m_magnitude, 8'hA0 + 8'(got));
            end
            tests++;
            if ((got == 0) ? (t !== 37) : (t - last_t !== 36)) begin
               failed++; $display("FAIL burst_spacing[%0d]: got cycle %0d (prev %0d) expected 37 then +36", got, t, last_t);
            end
            last_t = t;
            got++;
         end
      end
      s_valid = 1'b0;
      tests++;
      if (got !== 6 || !saw_full) begin failed++; $display("FAIL burst_count: got %0d results full=%0b expected 6,1", got, saw_full); end
      tick();
   endtask

   task automatic test_backpressure();
      int t, got;
      logic signed [15:0] ex [3];
      logic signed [15:0] ey [3];
      ex[0] = 16'sd5; ey[0] = 16'sd6;
      ex[1] = -16'sd1; ey[1] = 16'sd1;
      ex[2] = 16'sd2; ey[2] = 16'sd2;
      m_ready = 1'b0;
      s_x = 16'sd7; s_y = -16'sd2; s_tag = 8'h21; s_valid = 1'b1;
      tick(); s_valid = 1'b0; t = 1;
      while (!m_valid && t < 200) begin tick(); t++; end
      tests++;
      if (t !== 37) begin failed++; $display("FAIL bp_first_latency: got %0d expected 37", t); end
      for (int i = 0; i < 100; i++) begin
         s_valid = (i < 2);
         s_x = ex[i % 2]; s_y = ey[i % 2]; s_tag = (i == 0) ? 8'h22 : 8'h23;
         tick();
         tests++;
         if (m_valid !== 1'b1 || m_magnitude !== 32'd53 || m_phase !== 32'h0007_fffe || m_tag !== 8'h21 || eng_start !== 1'b0) begin
            failed++; $display("FAIL bp_hold[%0d]: mv=%0b mag=%0h ph=%0h tag=%0h start=%0b expected 1,35,7fffe,21,0",
                               i, m_valid, m_magnitude, m_phase, m_tag, eng_start);
         end
      end
      s_valid = 1'b0;
      tests++;
      if (fifo_level !== 3'd2) begin failed++; $display("FAIL bp_level: got %0d expected 2", fifo_level); end
      s_x = ex[2]; s_y = ey[2]; s_tag = 8'h24; s_valid = 1'b1; m_ready = 1'b1;
      tick(); s_valid = 1'b0;
      tests++;
      if (fifo_level !== 3'd2 || eng_start !== 1'b1 || eng_x !== 16'sd5 || eng_y !== 16'sd6 || m_valid !== 1'b0) begin
         failed++; $display("FAIL pushpop: lvl=%0d start=%0b x=%0d y=%0d mv=%0b expected 2,1,5,6,0", fifo_level, eng_start, eng_x, eng_y, m_valid);
      end
      t = 1; got = 0;
      while (got < 3 && t < 300) begin
         tick(); t++;
         if (m_valid) begin
            tests++;
            if (m_tag !== 8'h22 + 8'(got) || m_magnitude !== f_mag(ex[got], ey[got]) || m_phase !== f_ph(ex[got], ey[got])
                || (got == 0 && t !== 36)) begin
               failed++; $display("FAIL bp_drain[%0d]: tag=%0h mag=%0h cycle=%0d expected tag=%0h", got, m_tag, m_magnitude, t, 8'h22 + 8'(got));
            end
            got++;
         end
      end
      tests++;
      if (got !== 3) begin failed++; $display("FAIL bp_drain_count: got %0d expected 3", got); end
      tick();
   endtask

   task automatic test_timeout();
      int t;
      hang = 1'b1; m_ready = 1'b1;
      s_x = 16'sd1; s_y = 16'sd1; s_tag = 8'h31; s_valid = 1'b1;
      tick(); s_valid = 1'b0; t = 1;
      while (!err_timeout && t < 300) begin tick(); t++; end
      tests++;
      if (t !== 66 || m_valid !== 1'b0) begin failed++; $display("FAIL timeout_cycle: err at %0d mv=%0b expected 66,0", t, m_valid); end
      tick(); tick();
      hang = 1'b0;
      s_x = -16'sd3; s_y = -16'sd4; s_tag = 8'h32; s_valid = 1'b1;
      tick(); s_valid = 1'b0; tick(); t = 2;
      tests++;
      if (eng_start !== 1'b1 || eng_x !== -16'sd3 || eng_y !== -16'sd4) begin
         failed++; $display("FAIL timeout_reissue: start=%0b x=%0d y=%0d expected 1,-3,-4", eng_start, eng_x, eng_y);
      end
      while (!m_valid && t < 200) begin tick(); t++; end
      tests++;
      if (t !== 37 || m_tag !== 8'h32 || m_magnitude !== 32'd25 || err_timeout !== 1'b1) begin
         failed++; $display("FAIL timeout_next: cycle=%0d tag=%0h mag=%0h err=%0b expected 37,32,19,1", t, m_tag, m_magnitude, err_timeout);
      end
      tick();
   endtask

   task automatic test_reset_midjob();
      int t;
      m_ready = 1'b1;
      s_x = 16'sd9; s_y = 16'sd9; s_tag = 8'h41; s_valid = 1'b1;
      tick(); s_valid = 1'b0; t = 1;
      while (t < 31) begin tick(); t++; end
      rst = 1'b1;
      #1;
      tests++;
      if (s_ready !== 1'b0) begin failed++; $display("FAIL midrst_s_ready: got %0b expected 0", s_ready); end
      tick(); t++;
      rst = 1'b0;
      tests++;
      if ({eng_start, eng_x, eng_y, m_valid, m_tag, fifo_level, err_timeout} !== '0) begin
         failed++; $display("FAIL midrst_outputs: start=%0b x=%0d mv=%0b lvl=%0d err=%0b expected all 0",
                            eng_start, eng_x, m_valid, fifo_level, err_timeout);
      end
      s_x = 16'sd8; s_y = 16'sd6; s_tag = 8'h42; s_valid = 1'b1;
      tick(); t++; s_valid = 1'b0;
      while (t < 38) begin
         tests++;
         if (eng_start !== 1'b0 || m_valid !== 1'b0) begin
            failed++; $display("FAIL midrst_gate c%0d: start=%0b mv=%0b expected 0,0", t, eng_start, m_valid);
         end
         tick(); t++;
      end
      tests++;
      if (eng_start !== 1'b1 || eng_x !== 16'sd8 || eng_y !== 16'sd6) begin
         failed++; $display("FAIL midrst_issue: start=%0b x=%0d y=%0d expected 1,8,6", eng_start, eng_x, eng_y);
      end
      while (!m_valid && t < 200) begin tick(); t++; end
      tests++;
      if (t !== 73 || m_tag !== 8'h42 || m_magnitude !== 32'd100) begin
         failed++; $display("FAIL midrst_result: cycle=%0d tag=%0h mag=%0h expected 73,42,64", t, m_tag, m_magnitude);
      end
      tick();
   endtask

   task automatic test_protocol();
      tests++;
      if (viol !== 0) begin failed++; $display("FAIL start_protocol: got %0d bad starts expected 0", viol); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_timeout();
      test_reset_midjob();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time bound");
      $fatal(1);
   end
endmodule
`default_nettype wire
